// File: rtl/alu_sequencer.sv
// Clocked initiator for a combinational alu: accepts single or sweep commands, drives the alu
// from registers and returns each alu result through a valid/ready response register.
module alu_sequencer #(
    parameter int unsigned N       = 8,
    parameter int unsigned NUM_OPS = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [3:0]   cmd_op,
    input  logic         cmd_sign,
    input  logic         cmd_sweep,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_sign,
    input  logic [N-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_op,
    output logic         rsp_last,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    localparam logic [3:0] LastOp = 4'(NUM_OPS - 1);

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]   op_q, op_d;
    logic         sign_q, sign_d, sweep_q, sweep_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]   rsp_op_q, rsp_op_d;
    logic         rsp_last_q, rsp_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            sign_q       <= 1'b0;
            sweep_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            sign_q       <= sign_d;
            sweep_q      <= sweep_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        sign_d       = sign_q;
        sweep_d      = sweep_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_last_d   = rsp_last_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    sign_d  = cmd_sign;
                    sweep_d = cmd_sweep;
                    op_d    = cmd_sweep ? 4'd0 : cmd_op;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                rsp_result_d = alu_result;
                rsp_op_d     = op_q;
                rsp_last_d   = !sweep_q || (op_q == LastOp);
                rsp_valid_d  = 1'b1;
                state_d      = StHold;
            end
            StHold: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = StIdle;
                    end else begin
                        // NUM_OPS <= 16, so the 4-bit increment never wraps inside a sweep
                        op_d    = op_q + 4'd1;
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign alu_sign   = sign_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_last   = rsp_last_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with an xor alu stub and a response-list reference model.
module tb_alu_sequencer;

    localparam int N       = 8;
    localparam int NUM_OPS = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [N-1:0] cmd_a = '0;
    logic [N-1:0] cmd_b = '0;
    logic [3:0]   cmd_op = '0;
    logic         cmd_sign = 1'b0;
    logic         cmd_sweep = 1'b0;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_op;
    logic         alu_sign;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_op;
    logic         rsp_last;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign alu_result = alu_a ^ alu_b ^ {{N-4{1'b0}}, alu_op};

    alu_sequencer #(.N(N), .NUM_OPS(NUM_OPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_sign   (cmd_sign),
        .cmd_sweep  (cmd_sweep),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_sign   (alu_sign),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one command to completion; expected responses come from the opcode list the command implies.
    task automatic run_cmd(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [3:0] op, input logic sign, input logic sweep,
                           input int stall_pct, output int busy_cycles, output int n_rsp);
        logic [N-1:0] exp_res[$];
        logic [3:0]   exp_op[$];
        logic         exp_last[$];
        int cnt, cyc, first_seen, wait_cyc;
        logic [3:0] o;
        cnt = sweep ? NUM_OPS : 1;
        for (int i = 0; i < cnt; i++) begin
            o = sweep ? 4'(i) : op;
            exp_res.push_back(a ^ b ^ {{N-4{1'b0}}, o});
            exp_op.push_back(o);
            exp_last.push_back(i == cnt - 1);
        end
        busy_cycles = 0;
        n_rsp = 0;
        first_seen = -1;
        wait_cyc = 0;
        while (!cmd_ready && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_sign = sign; cmd_sweep = sweep;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            if (busy) busy_cycles++;
            n_checks++;
            if (cmd_ready !== !busy)
                $display("FAIL %s cmd_ready: got %b required %b", name, cmd_ready, !busy);
            else n_pass++;
            if (busy) begin
                n_checks++;
                if ({alu_a, alu_b, alu_sign} !== {a, b, sign})
                    $display("FAIL %s alu_operands: got %h/%h/%b required %h/%h/%b",
                             name, alu_a, alu_b, alu_sign, a, b, sign);
                else n_pass++;
            end
            if (rsp_valid) begin
                if (first_seen < 0) first_seen = cyc;
                n_checks++;
                if (exp_res.size() == 0)
                    $display("FAIL %s extra_rsp: got op %0d required none", name, rsp_op);
                else if ({rsp_result, rsp_op, rsp_last, alu_op} !==
                         {exp_res[0], exp_op[0], exp_last[0], exp_op[0]})
                    $display("FAIL %s rsp: got res %h op %0d last %b alu_op %0d required %h %0d %b",
                             name, rsp_result, rsp_op, rsp_last, alu_op,
                             exp_res[0], exp_op[0], exp_last[0]);
                else n_pass++;
            end
            if (!busy && exp_res.size() == 0) break;
            rsp_ready = ($urandom_range(99) >= stall_pct);
            if (rsp_valid && rsp_ready && exp_res.size() != 0) begin
                void'(exp_res.pop_front());
                void'(exp_op.pop_front());
                void'(exp_last.pop_front());
                n_rsp++;
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (exp_res.size() != 0 || busy)
            $display("FAIL %s completion: got %0d outstanding busy %b required 0 0",
                     name, exp_res.size(), busy);
        else n_pass++;
        n_checks++;
        if (first_seen != 1)
            $display("FAIL %s latency: got %0d required 1", name, first_seen);
        else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int wait_cyc;
        int stray;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({cmd_ready, busy, rsp_valid, alu_a, alu_b, alu_op, alu_sign, rsp_result, rsp_op, rsp_last}
            !== {1'b1, 1'b0, 1'b0, {N{1'b0}}, {N{1'b0}}, 4'd0, 1'b0, {N{1'b0}}, 4'd0, 1'b0})
            $display("FAIL reset_state: got rdy %b busy %b vld %b a %h b %h op %0d required 1 0 0 0 0 0",
                     cmd_ready, busy, rsp_valid, alu_a, alu_b, alu_op);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        // Reach HOLD with backpressure, then reset asynchronously
        rsp_ready = 1'b0;
        cmd_a = 8'h5A; cmd_b = 8'h11; cmd_op = 4'd2; cmd_sign = 1'b0; cmd_sweep = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_cyc = 0;
        while (!rsp_valid && wait_cyc < 10) begin
            tick();
            wait_cyc++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL reset_reach_hold: got %b required 1", rsp_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001)
            $display("FAIL reset_mid_hold: got vld %b busy %b rdy %b required 0 0 1",
                     rsp_valid, busy, cmd_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid || busy) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL reset_no_stray: got %0d active cycles required 0", stray);
        else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        cmd_a = 8'h0F; cmd_b = 8'h03; cmd_op = 4'd4; cmd_sign = 1'b0; cmd_sweep = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({busy, cmd_ready, rsp_valid, alu_op} !== {1'b1, 1'b0, 1'b0, 4'd4})
            $display("FAIL single_issue: got busy %b rdy %b vld %b op %0d required 1 0 0 4",
                     busy, cmd_ready, rsp_valid, alu_op);
        else n_pass++;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_op, rsp_last} !== {1'b1, 8'h08, 4'd4, 1'b1})
            $display("FAIL single_rsp: got vld %b res %h op %0d last %b required 1 08 4 1",
                     rsp_valid, rsp_result, rsp_op, rsp_last);
        else n_pass++;
        tick();
        n_checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001)
            $display("FAIL single_done: got vld %b busy %b rdy %b required 0 0 1",
                     rsp_valid, busy, cmd_ready);
        else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_sweep(input string name, input logic [N-1:0] a, input logic sign);
        int bc, nr;
        run_cmd(name, a, 8'h03, 4'd0, sign, 1'b1, 0, bc, nr);
        n_checks++;
        if (bc != 2 * NUM_OPS) $display("FAIL %s busy_cycles: got %0d required %0d", name, bc, 2 * NUM_OPS);
        else n_pass++;
        n_checks++;
        if (nr != NUM_OPS) $display("FAIL %s rsp_count: got %0d required %0d", name, nr, NUM_OPS);
        else n_pass++;
    endtask

    task automatic test_out_of_range_op();
        int bc, nr;
        run_cmd("single_op_high", 8'hC3, 8'h3C, 4'd13, 1'b1, 1'b0, 0, bc, nr);
        n_checks++;
        if (bc != 2 || nr != 1) $display("FAIL single_op_high_len: got %0d/%0d required 2/1", bc, nr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] r;
        logic [3:0] o;
        logic l;
        int bad;
        rsp_ready = 1'b0;
        cmd_a = 8'h21; cmd_b = 8'h40; cmd_sign = 1'b0; cmd_sweep = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_a = 8'hEE; cmd_b = 8'hEE;
        tick();
        r = rsp_result; o = rsp_op; l = rsp_last;
        n_checks++;
        if ({rsp_valid, r, o, l} !== {1'b1, 8'h61, 4'd0, 1'b0})
            $display("FAIL bp_first: got vld %b res %h op %0d last %b required 1 61 0 0",
                     rsp_valid, r, o, l);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({rsp_valid, rsp_result, rsp_op, rsp_last, alu_op, cmd_ready, busy}
                !== {1'b1, r, o, l, 4'd0, 1'b0, 1'b1}) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles required 0", bad);
        else n_pass++;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        n_checks++;
        if ({rsp_valid, alu_op, busy} !== {1'b0, 4'd1, 1'b1})
            $display("FAIL bp_release: got vld %b op %0d busy %b required 0 1 1",
                     rsp_valid, alu_op, busy);
        else n_pass++;
        for (int i = 0; i < 4 * NUM_OPS && busy; i++) tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL bp_drain: got busy %b required 0", busy);
        else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_cmd_held();
        int bc, bad;
        rsp_ready = 1'b1;
        cmd_a = 8'h12; cmd_b = 8'h34; cmd_sign = 1'b0; cmd_sweep = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_a = 8'hAB; cmd_b = 8'hCD; cmd_op = 4'd7; cmd_sign = 1'b1; cmd_sweep = 1'b0;
        bc = 0;
        bad = 0;
        while (busy && bc < 4 * NUM_OPS) begin
            if (cmd_ready || alu_a !== 8'h12 || alu_b !== 8'h34) bad++;
            bc++;
            tick();
        end
        n_checks++;
        if (bad != 0 || bc != 2 * NUM_OPS)
            $display("FAIL held_no_accept: got %0d bad over %0d cycles required 0 over %0d",
                     bad, bc, 2 * NUM_OPS);
        else n_pass++;
        tick();
        n_checks++;
        if ({busy, alu_a, alu_b, alu_op, alu_sign} !== {1'b1, 8'hAB, 8'hCD, 4'd7, 1'b1})
            $display("FAIL held_accept: got busy %b a %h b %h op %0d sign %b required 1 ab cd 7 1",
                     busy, alu_a, alu_b, alu_op, alu_sign);
        else n_pass++;
        cmd_valid = 1'b0;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_last} !== {1'b1, 8'h61, 1'b1})
            $display("FAIL held_rsp: got vld %b res %h last %b required 1 61 1",
                     rsp_valid, rsp_result, rsp_last);
        else n_pass++;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int bc, nr;
        logic [N-1:0] a, b;
        logic [3:0] op;
        logic sign, sweep;
        for (int t = 0; t < 12; t++) begin
            a = N'($urandom);
            b = N'($urandom);
            op = 4'($urandom_range(15));
            sign = 1'($urandom);
            sweep = 1'($urandom);
            run_cmd("random", a, b, op, sign, sweep, 40, bc, nr);
            n_checks++;
            if (nr != (sweep ? NUM_OPS : 1))
                $display("FAIL random_count: got %0d required %0d", nr, sweep ? NUM_OPS : 1);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep("sweep_unsigned", 8'h0F, 1'b0);
        test_sweep("sweep_signed", 8'h8F, 1'b1);
        test_out_of_range_op();
        test_backpressure();
        test_cmd_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
